// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and width helpers for the symmetric FIR scheduler
package fir_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;
  function automatic int pair_w(int data_w);
    return data_w + 1;
  endfunction
  function automatic int prod_w(int data_w, int coeff_w);
    return pair_w(data_w) + coeff_w;
  endfunction
  function automatic int acc_w(int data_w, int coeff_w, int tap);
    return prod_w(data_w, coeff_w) + $clog2(tap / 2);
  endfunction
endpackage

// File: rtl/fir_sym_mac_sched_if.sv
// fir_sym_mac_sched_if: sample, coefficient and output handshake bundle
interface fir_sym_mac_sched_if #(
    parameter int DATA_W  = 24,
    parameter int COEFF_W = 16,
    parameter int TAP     = 16
);
    import fir_pkg::*;
    localparam int NPAIR = TAP / 2;
    localparam int AW    = $clog2(NPAIR);
    localparam int ACC_W = acc_w(DATA_W, COEFF_W, TAP);
    logic                      s_valid;
    logic                      s_ready;
    logic signed [DATA_W-1:0]  s_data;
    logic                      coef_we;
    logic [AW-1:0]             coef_addr;
    logic signed [COEFF_W-1:0] coef_data;
    logic                      m_valid;
    logic                      m_ready;
    logic signed [ACC_W-1:0]   m_data;
    logic                      busy;
    modport master (
        output s_valid, s_data, coef_we, coef_addr, coef_data, m_ready,
        input  s_ready, m_valid, m_data, busy
    );
    modport slave (
        input  s_valid, s_data, coef_we, coef_addr, coef_data, m_ready,
        output s_ready, m_valid, m_data, busy
    );
endinterface

// File: rtl/fir_pair_mac.sv
// fir_pair_mac: 3-stage pair-sum, multiply and accumulate pipeline
module fir_pair_mac #(
    parameter int DATA_W  = 24,
    parameter int COEFF_W = 16,
    parameter int TAP     = 16
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               clr,
    input  logic                                               issue,
    input  logic signed [DATA_W-1:0]                           xa,
    input  logic signed [DATA_W-1:0]                           xb,
    input  logic signed [COEFF_W-1:0]                          coef,
    output logic signed [fir_pkg::acc_w(DATA_W, COEFF_W, TAP)-1:0] acc
);
    import fir_pkg::*;
    localparam int PAIR_W = pair_w(DATA_W);
    localparam int PROD_W = prod_w(DATA_W, COEFF_W);
    localparam int ACC_W  = acc_w(DATA_W, COEFF_W, TAP);
    logic signed [PAIR_W-1:0]  sum_q;
    logic signed [COEFF_W-1:0] c_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic                      v1_q, v2_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            sum_q  <= '0;
            c_q    <= '0;
            prod_q <= '0;
            acc    <= '0;
        end else begin
            v1_q   <= issue;
            v2_q   <= v1_q;
            sum_q  <= PAIR_W'(xa) + PAIR_W'(xb);
            c_q    <= coef;
            prod_q <= PROD_W'(sum_q) * PROD_W'(c_q);
            acc    <= clr ? '0 : v2_q ? acc + ACC_W'(prod_q) : acc;
        end
    end
endmodule

// File: rtl/fir_sym_mac_sched.sv
// fir_sym_mac_sched: time-multiplexed symmetric FIR, one shared MAC over TAP/2 pairs
module fir_sym_mac_sched #(
    parameter int DATA_W  = 24,
    parameter int COEFF_W = 16,
    parameter int TAP     = 16
) (
    input logic                clk,
    input logic                rst,
    fir_sym_mac_sched_if.slave bus
);
    import fir_pkg::*;
    localparam int NPAIR = TAP / 2;
    localparam int AW    = $clog2(NPAIR);
    localparam int PW    = $clog2(TAP);
    localparam int ACC_W = acc_w(DATA_W, COEFF_W, TAP);
    sched_state_t              state_q, state_d;
    logic signed [DATA_W-1:0]  x_q [TAP];
    logic signed [COEFF_W-1:0] h_q [NPAIR];
    logic [PW-1:0]             wp_q, np, ia, ib;
    logic [AW-1:0]             k_q;
    logic                      d_q, accept, issue, last;
    logic signed [ACC_W-1:0]   acc;
    // circular-buffer index of delay d relative to the newest sample p
    function automatic logic [PW-1:0] back(logic [PW-1:0] p, int d);
        int t;
        t = int'(p) - d;
        return PW'(t < 0 ? t + TAP : t);
    endfunction
    always_comb begin
        accept = state_q == IDLE && bus.s_valid;
        issue  = state_q == RUN;
        last   = k_q == AW'(NPAIR - 1);
        np     = wp_q == '0 ? PW'(TAP - 1) : wp_q - 1'b1;
        ia     = back(np, int'(k_q));
        ib     = back(np, TAP - 1 - int'(k_q));
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.s_valid ? RUN : IDLE;
            RUN:     state_d = last ? DRAIN : RUN;
            DRAIN:   state_d = d_q ? DONE : DRAIN;
            DONE:    state_d = bus.m_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wp_q    <= '0;
            k_q     <= '0;
            d_q     <= 1'b0;
            for (int i = 0; i < TAP; i++) x_q[i] <= '0;
            for (int i = 0; i < NPAIR; i++) h_q[i] <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= accept ? '0 : issue ? k_q + 1'b1 : k_q;
            d_q     <= state_q == DRAIN ? ~d_q : 1'b0;
            if (accept) begin
                x_q[wp_q] <= bus.s_data;
                wp_q      <= wp_q == PW'(TAP - 1) ? '0 : wp_q + 1'b1;
            end
            // coefficient bank is frozen while a computation is in flight
            if (state_q == IDLE && bus.coef_we) h_q[bus.coef_addr] <= bus.coef_data;
        end
    end
    fir_pair_mac #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .TAP(TAP)) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .issue(issue),
        .xa   (x_q[ia]),
        .xb   (x_q[ib]),
        .coef (h_q[k_q]),
        .acc  (acc)
    );
    assign bus.s_ready = state_q == IDLE;
    assign bus.m_valid = state_q == DONE;
    assign bus.busy    = state_q != IDLE;
    assign bus.m_data  = acc;
endmodule

// File: tb/tb_fir_sym_mac_sched.sv
// tb_fir_sym_mac_sched: directed + randomized checks against a plain-arithmetic FIR model
module tb_fir_sym_mac_sched;
    localparam int DATA_W  = 24;
    localparam int COEFF_W = 16;
    localparam int TAP     = 16;
    localparam int NPAIR   = TAP / 2;
    localparam int LAT     = NPAIR + 3;
    localparam int PERIOD  = NPAIR + 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0, passed = 0;
    longint cyc = 0, last_acc = 0;
    longint mx [TAP];
    longint mh [NPAIR];
    fir_sym_mac_sched_if #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .TAP(TAP)) bus ();
    fir_sym_mac_sched #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .TAP(TAP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask
    // y = sum_k h[k] * (x[n-k] + x[n-(TAP-1-k)]), mx[0] is the newest sample
    function automatic longint model_y();
        longint y = 0;
        for (int k = 0; k < NPAIR; k++) y += mh[k] * (mx[k] + mx[TAP - 1 - k]);
        return y;
    endfunction
    task automatic model_reset();
        for (int i = 0; i < TAP; i++) mx[i] = 0;
        for (int i = 0; i < NPAIR; i++) mh[i] = 0;
    endtask
    task automatic wr_coef(input int a, input longint d);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 3'(a);
        bus.coef_data = COEFF_W'(d);
        @(negedge clk);
        bus.coef_we = 1'b0;
        mh[a] = d;
    endtask
    // call at a negedge with the block idle; returns the observed output
    task automatic run_sample(input longint v, input int hold, input bit busy_wr, input bit idle_wr,
                              input int wa, input longint wd, input bit spaced, output longint y);
        longint exp;
        int c;
        logic signed [63:0] held;
        chk("s_ready_idle", bus.s_ready, 1);
        bus.s_valid = 1'b1;
        bus.s_data  = DATA_W'(v);
        if (idle_wr) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = 3'(wa);
            bus.coef_data = COEFF_W'(wd);
            mh[wa] = wd;
        end
        if (spaced) chk("accept_spacing", cyc - last_acc, PERIOD);
        last_acc = cyc;
        @(posedge clk);
        for (int i = TAP - 1; i > 0; i--) mx[i] = mx[i - 1];
        mx[0] = v;
        exp = model_y();
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.coef_we = 1'b0;
        chk("busy_run", bus.busy, 1);
        chk("s_ready_run", bus.s_ready, 0);
        c = 1;
        while (bus.m_valid !== 1'b1 && c < 40) begin
            bus.coef_we = busy_wr && c == 3;
            bus.coef_addr = 3'(wa);
            bus.coef_data = COEFF_W'(wd);
            @(negedge clk);
            c++;
        end
        bus.coef_we = 1'b0;
        chk("latency", c, LAT);
        chk("m_data", bus.m_data, exp);
        held = bus.m_data;
        y = bus.m_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_hold", bus.m_data, held);
            chk("bp_s_ready", bus.s_ready, 0);
            chk("bp_m_valid", bus.m_valid, 1);
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        chk("s_ready_after", bus.s_ready, 1);
        chk("m_valid_after", bus.m_valid, 0);
    endtask
    initial begin
        longint y;
        bit seen;
        bus.s_valid = 0; bus.s_data = 0; bus.coef_we = 0;
        bus.coef_addr = 0; bus.coef_data = 0; bus.m_ready = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        @(negedge clk);
        // impulse response with back-to-back samples
        for (int k = 0; k < NPAIR; k++) wr_coef(k, k + 1);
        for (int i = 0; i < TAP; i++) begin
            run_sample(i == 0 ? 1 : 0, 0, 0, 0, 0, 0, i > 0, y);
            chk("impulse", y, i < NPAIR ? i + 1 : TAP - i);
        end
        // backpressure
        run_sample(longint'($urandom_range(0, 2**24 - 1)) - 2**23, 20, 0, 0, 0, 0, 0, y);
        // write while busy is ignored, then flush and re-run impulse
        run_sample(0, 0, 1, 0, 0, 100, 0, y);
        for (int i = 0; i < TAP - 1; i++) run_sample(0, 0, 0, 0, 0, 0, 1, y);
        run_sample(1, 0, 0, 0, 0, 0, 1, y);
        chk("impulse_after_busy_wr", y, 1);
        // write in IDLE together with s_valid takes effect for this sample
        run_sample(1, 0, 0, 1, 0, 100, 0, y);
        chk("idle_wr_same_edge", y, 102);
        // randomized samples, coefficients and backpressure
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) wr_coef($urandom_range(0, NPAIR - 1), longint'($urandom_range(0, 65535)) - 32768);
            run_sample(longint'($urandom_range(0, 2**24 - 1)) - 2**23, $urandom_range(0, 3), 0, 0, 0, 0, 0, y);
        end
        // DC extremes
        for (int k = 0; k < NPAIR; k++) wr_coef(k, -32768);
        run_sample(-(2**23), 0, 0, 0, 0, 0, 0, y);
        for (int i = 1; i < TAP; i++) run_sample(-(2**23), 0, 0, 0, 0, 0, 1, y);
        chk("dc_extreme", y, 64'sd1 <<< 42);
        // reset mid-RUN aborts the computation
        bus.s_valid = 1'b1;
        bus.s_data  = DATA_W'($urandom);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("abort_busy", bus.busy, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.m_valid !== 1'b0) seen = 1;
        end
        chk("abort_no_m_valid", seen, 0);
        run_sample(1, 0, 0, 0, 0, 0, 0, y);
        chk("post_reset_impulse", y, 0);
        for (int k = 0; k < NPAIR; k++) wr_coef(k, k + 1);
        run_sample(0, 0, 0, 0, 0, 0, 0, y);
        chk("post_reset_delay_line", y, 2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
